// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between a binary producer and the
// sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
  parameter int W      = 14,
  parameter int DIGITS = 4
) ();

  logic                  i_start;
  logic [W-1:0]          i_bin;
  logic                  o_ready;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd;
  logic                  o_overflow;

  // Producer side: issues start/value, observes handshake and result.
  modport master (
    output i_start,
    output i_bin,
    input  o_ready,
    input  o_done,
    input  o_bcd,
    input  o_overflow
  );

  // Converter side.
  modport slave (
    input  i_start,
    input  i_bin,
    output o_ready,
    output o_done,
    output o_bcd,
    output o_overflow
  );

endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
// One conversion per start/ready handshake: W shift cycles plus one result
// cycle. Out-of-range inputs saturate the display to all nines and raise
// o_overflow. The last result is held between conversions.
module bin2bcd_seq #(
  parameter int W      = 14,
  parameter int DIGITS = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  bin2bcd_seq_if.slave  bus
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          CNT_W   = (W > 1) ? $clog2(W) : 1;
  localparam logic [63:0] MAX_VAL = 64'(10**DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Add 3 to every digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit. A 4-bit digit of at most
  // 9 becomes at most 4'hC, so the add never wraps.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = s[4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Values that do not fit in DIGITS decimal digits show as all nines.
  function automatic logic [BCD_W-1:0] saturate_bcd(input logic             ovf,
                                                    input logic [BCD_W-1:0] s);
    return ovf ? {DIGITS{4'h9}} : s;
  endfunction

  // True when the binary value exceeds the largest displayable number.
  function automatic logic over_range(input logic [W-1:0] b);
    logic [63:0] e;
    e        = '0;
    e[W-1:0] = b;
    return (e > MAX_VAL);
  endfunction

  state_t             state_q,   state_d;
  logic [W-1:0]       shift_q,   shift_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               ovf_q,     ovf_d;
  logic [BCD_W-1:0]   bcd_q,     bcd_d;
  logic               ovfo_q,    ovfo_d;
  logic               done_q,    done_d;
  logic [BCD_W-1:0]   adj;

  assign adj            = dabble_adjust(scratch_q);
  assign bus.o_ready    = (state_q == IDLE);
  assign bus.o_done     = done_q;
  assign bus.o_bcd      = bcd_q;
  assign bus.o_overflow = ovfo_q;

  // Next-state and datapath: capture in IDLE, adjust+shift in SHIFT,
  // publish the result in DONE.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bcd_d     = bcd_q;
    ovfo_d    = ovfo_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          shift_d   = bus.i_bin;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_d     = over_range(bus.i_bin);
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        // The bit shifted out of the top digit is dropped; over_range
        // already flagged any value large enough to produce it.
        {scratch_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(W - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        bcd_d   = saturate_bcd(ovf_q, scratch_q);
        ovfo_d  = ovf_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion and clears
  // the published result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bcd_q     <= '0;
      ovfo_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bcd_q     <= bcd_d;
      ovfo_q    <= ovfo_d;
      done_q    <= done_d;
    end
  end

endmodule
